duck_palette_encoder: RTL and testbench

//  RGB-to-palette-index encoder for the 16-entry, 4-bit-per-channel duck sprite palette.
//  It is the inverse of the index->RGB palette lookup.

---
 rtl/duck_palette_pkg.sv | 35 +++
 rtl/color_distance.sv | 22 ++
 rtl/duck_palette_encoder.sv | 138 +++++++++++++
 tb/tb_duck_palette_encoder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/duck_palette_pkg.sv
// Shared types and constants for the duck sprite palette encoder.
//   rgb_t           : 12-bit {R,G,B} colour, 4 bits per channel
//   idx_t           : palette index
//   enc_state_t     : encoder FSM states
//   DEFAULT_PALETTE : table the palette regfile reloads on reset
//   abs_diff        : unsigned absolute difference of one colour channel
package duck_palette_pkg;

  localparam int unsigned NUM_ENTRIES = 16;
  localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES);
  localparam int unsigned CH_W        = 4;
  localparam int unsigned RGB_W       = 3 * CH_W;
  localparam int unsigned DIST_W      = CH_W + 2;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DIST_W-1:0] dist_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } enc_state_t;

  localparam rgb_t DEFAULT_PALETTE [0:NUM_ENTRIES-1] = '{
    12'hAEA, 12'h00A, 12'hFFF, 12'hF76, 12'hB0B, 12'hFFF, 12'hFFF, 12'hFFF,
    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF
  };

  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/color_distance.sv
// Combinational Manhattan distance between two {R,G,B} colours.
//   i_a, i_b : colours to compare
//   o_dist   : |dR| + |dG| + |dB|, unsigned, wide enough for the 3*15 maximum
module color_distance
  import duck_palette_pkg::*;
(
  input  logic [RGB_W-1:0]  i_a,
  input  logic [RGB_W-1:0]  i_b,
  output logic [DIST_W-1:0] o_dist
);

  logic [CH_W-1:0] w_d_r;
  logic [CH_W-1:0] w_d_g;
  logic [CH_W-1:0] w_d_b;

  assign w_d_r = abs_diff(i_a[2*CH_W +: CH_W], i_b[2*CH_W +: CH_W]);
  assign w_d_g = abs_diff(i_a[CH_W +: CH_W],   i_b[CH_W +: CH_W]);
  assign w_d_b = abs_diff(i_a[0 +: CH_W],      i_b[0 +: CH_W]);

  assign o_dist = {2'b00, w_d_r} + {2'b00, w_d_g} + {2'b00, w_d_b};

endmodule

// File: rtl/duck_palette_encoder.sv
// RGB-to-palette-index encoder for the 16-entry duck sprite palette.
// Scans the run-time-writable palette one entry per cycle and returns the exact
// match index, or the nearest entry by Manhattan distance (lowest index on ties).
//   Clk, Reset_n                    : clock, async active-low reset
//   pal_we/pal_waddr/pal_wdata      : palette write port, any state
//   in_valid/in_ready/in_rgb        : colour request handshake
//   out_valid/out_ready             : result handshake
//   out_index/out_exact             : result index and exact-match flag
module duck_palette_encoder
  import duck_palette_pkg::*;
#(
  parameter int unsigned TRANSPARENT_IDX  = 0,
  parameter bit          SKIP_TRANSPARENT = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             pal_we,
  input  logic [IDX_W-1:0] pal_waddr,
  input  logic [RGB_W-1:0] pal_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RGB_W-1:0] in_rgb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_exact
);

  enc_state_t r_state, w_state_next;
  rgb_t       r_pal [NUM_ENTRIES];
  rgb_t       r_rgb, w_rgb_next;
  idx_t       r_idx, w_idx_next;
  dist_t      r_best_dist, w_best_dist_next;
  idx_t       r_best_idx, w_best_idx_next;
  idx_t       r_out_index, w_out_index_next;
  logic       r_out_exact, w_out_exact_next;

  dist_t      w_dist;
  logic       w_consider;
  logic       w_better;
  logic       w_last;

  color_distance u_color_distance (
    .i_a    (r_rgb),
    .i_b    (r_pal[r_idx]),
    .o_dist (w_dist)
  );

  // The transparent entry may only win by exact match; the exact case is
  // handled before this flag is used, so here it simply blocks that entry.
  assign w_consider = !(SKIP_TRANSPARENT && (r_idx == IDX_W'(TRANSPARENT_IDX)));
  assign w_better   = w_consider && (w_dist < r_best_dist);
  assign w_last     = (r_idx == IDX_W'(NUM_ENTRIES - 1));

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign out_index = r_out_index;
  assign out_exact = r_out_exact;

  // Palette regfile: a compare in the same cycle as a write sees the old value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_pal[i] <= DEFAULT_PALETTE[i];
      end
    end else if (pal_we) begin
      r_pal[pal_waddr] <= pal_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= StIdle;
      r_rgb       <= '0;
      r_idx       <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_out_index <= '0;
      r_out_exact <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rgb       <= w_rgb_next;
      r_idx       <= w_idx_next;
      r_best_dist <= w_best_dist_next;
      r_best_idx  <= w_best_idx_next;
      r_out_index <= w_out_index_next;
      r_out_exact <= w_out_exact_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_rgb_next       = r_rgb;
    w_idx_next       = r_idx;
    w_best_dist_next = r_best_dist;
    w_best_idx_next  = r_best_idx;
    w_out_index_next = r_out_index;
    w_out_exact_next = r_out_exact;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_rgb_next       = in_rgb;
          w_idx_next       = '0;
          w_best_dist_next = '1;
          w_best_idx_next  = '0;
          w_state_next     = StSearch;
        end
      end
      StSearch: begin
        if (w_dist == '0) begin
          w_out_index_next = r_idx;
          w_out_exact_next = 1'b1;
          w_state_next     = StDone;
        end else begin
          if (w_better) begin
            w_best_dist_next = w_dist;
            w_best_idx_next  = r_idx;
          end
          if (w_last) begin
            // Best register has not absorbed this cycle's entry yet.
            w_out_index_next = w_better ? r_idx : r_best_idx;
            w_out_exact_next = 1'b0;
            w_state_next     = StDone;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_duck_palette_encoder.sv
module tb_duck_palette_encoder;

  logic        Clk;
  logic        Reset_n;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_exact;

  int n_checks;
  int n_errors;

  duck_palette_encoder dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .pal_we    (pal_we),
    .pal_waddr (pal_waddr),
    .pal_wdata (pal_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_exact (out_exact)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the encoder idle. Latency counts edges after the accept edge.
  task automatic run_job(input string tag, input logic [11:0] rgb, input int exp_idx,
                         input bit exp_exact, input int exp_lat, input bit release_out);
    int lat;
    bit seen;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_rgb   = rgb;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge Clk); #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_index"}, 32'(out_index), 32'(exp_idx));
    check({tag, "_exact"}, 32'(out_exact), 32'(exp_exact));
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    Reset_n   = 1'b0;
    pal_we    = 1'b0;
    pal_waddr = '0;
    pal_wdata = '0;
    in_valid  = 1'b0;
    in_rgb    = '0;
    out_ready = 1'b0;
    #12 Reset_n = 1'b1;
    @(posedge Clk); #1;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_exact", 32'(out_exact), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Exact hits, nearest matches, transparent skip.
    run_job("b0b", 12'hB0B, 4, 1'b1, 5, 1'b1);
    run_job("fff", 12'hFFF, 2, 1'b1, 3, 1'b1);
    run_job("f66", 12'hF66, 3, 1'b0, 16, 1'b1);
    run_job("aea", 12'hAEA, 0, 1'b1, 1, 1'b1);
    run_job("aeb", 12'hAEB, 2, 1'b0, 16, 1'b1);

    // Backpressure: result held, no new job accepted.
    run_job("bp", 12'h00A, 1, 1'b1, 2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_rgb   = 12'hFFF;
      @(posedge Clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_index", 32'(out_index), 32'd1);
      check("bp_hold_exact", 32'(out_exact), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge Clk); #1;
    check("bp_no_stray_job", 32'(in_ready), 32'd1);

    // Palette write then lookup of the new colour.
    pal_we    = 1'b1;
    pal_waddr = 4'd7;
    pal_wdata = 12'h123;
    @(posedge Clk); #1;
    pal_we = 1'b0;
    run_job("wr123", 12'h123, 7, 1'b1, 8, 1'b1);

    // Reset in the middle of a full search.
    in_valid = 1'b1;
    in_rgb   = 12'h0F0;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_index", 32'(out_index), 32'd0);
    check("midrst_exact", 32'(out_exact), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    #3 Reset_n = 1'b1;
    @(posedge Clk); #1;
    run_job("post_fff", 12'hFFF, 2, 1'b1, 3, 1'b1);
    // Entry 7 is back to FFF, so 123 now lands on 00A (distance 10).
    run_job("post_123", 12'h123, 1, 1'b0, 16, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
